// File: rtl/alu_result_router.sv
// alu_result_router: registered 1-to-4 result router with per-channel valid/ready holding registers
module alu_result_router #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_bcast,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]   xfer_count
);
  logic [3:0] can_accept;
  logic [3:0] load;
  logic       accept;
  // a channel takes new data when empty or being drained this cycle; broadcast needs all four
  always_comb begin
    can_accept = ~out_valid | out_ready;
    in_ready   = in_bcast ? &can_accept : can_accept[in_sel];
    accept     = in_valid && in_ready;
    load       = accept ? (in_bcast ? 4'hF : 4'b0001 << in_sel) : 4'h0;
  end
  // channel holding registers: load wins over drain, reset discards everything
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load[i]) begin
          out_valid[i]               <= 1'b1;
          out_data[i*WIDTH +: WIDTH] <= in_data;
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
    end
  end
  // saturating count of accepted transfers, one per broadcast
  always_ff @(posedge clk) begin
    if (rst) xfer_count <= '0;
    else if (accept && xfer_count != '1) xfer_count <= xfer_count + 1'b1;
  end
endmodule

// File: tb/tb_alu_result_router.sv
// tb_alu_result_router: table-driven directed check of the result router
module tb_alu_result_router;
  logic        clk = 0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_bcast;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic [3:0]  xfer_count;
  int checks = 0;
  int errors = 0;

  alu_result_router #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [7:0]  d;
    logic [1:0]  sel;
    logic        bc;
    logic [3:0]  ordy;
    logic        rdy;
    logic [3:0]  v;
    logic [31:0] data;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tv[$];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    rst = t.rst; in_valid = t.iv; in_data = t.d; in_sel = t.sel; in_bcast = t.bc; out_ready = t.ordy;
    #1;
    check("in_ready", idx, {31'b0, in_ready}, {31'b0, t.rdy});
    @(posedge clk);
    #1;
    check("out_valid", idx, {28'b0, out_valid}, {28'b0, t.v});
    check("out_data", idx, out_data, t.data);
    check("xfer_count", idx, {28'b0, xfer_count}, {28'b0, t.cnt});
  endtask

  initial begin
    // rst iv  data   sel bc ordy      rdy valid     data          cnt
    tv.push_back('{1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 4'b0000, 1'b1, 4'b0000, 32'h00000000, 4'd0});
    tv.push_back('{1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0000, 32'h00000000, 4'd0});
    tv.push_back('{1'b0, 1'b1, 8'hA5, 2'd2, 1'b0, 4'b0000, 1'b1, 4'b0100, 32'h00A50000, 4'd1});
    tv.push_back('{1'b0, 1'b1, 8'h11, 2'd0, 1'b0, 4'b0000, 1'b1, 4'b0101, 32'h00A50011, 4'd2});
    tv.push_back('{1'b0, 1'b1, 8'h22, 2'd1, 1'b0, 4'b0000, 1'b1, 4'b0111, 32'h00A52211, 4'd3});
    tv.push_back('{1'b0, 1'b0, 8'h00, 2'd3, 1'b0, 4'b0100, 1'b1, 4'b0011, 32'h00A52211, 4'd3});
    tv.push_back('{1'b0, 1'b1, 8'h33, 2'd2, 1'b0, 4'b0000, 1'b1, 4'b0111, 32'h00332211, 4'd4});
    tv.push_back('{1'b0, 1'b1, 8'h44, 2'd3, 1'b0, 4'b0000, 1'b1, 4'b1111, 32'h44332211, 4'd5});
    tv.push_back('{1'b0, 1'b1, 8'h55, 2'd1, 1'b0, 4'b0000, 1'b0, 4'b1111, 32'h44332211, 4'd5});
    tv.push_back('{1'b0, 1'b1, 8'h55, 2'd0, 1'b0, 4'b0001, 1'b1, 4'b1111, 32'h44332255, 4'd6});
    tv.push_back('{1'b0, 1'b1, 8'h66, 2'd0, 1'b0, 4'b0001, 1'b1, 4'b1111, 32'h44332266, 4'd7});
    tv.push_back('{1'b0, 1'b1, 8'h77, 2'd0, 1'b0, 4'b0001, 1'b1, 4'b1111, 32'h44332277, 4'd8});
    tv.push_back('{1'b0, 1'b0, 8'h00, 2'd3, 1'b0, 4'b0111, 1'b0, 4'b1000, 32'h44332277, 4'd8});
    tv.push_back('{1'b0, 1'b1, 8'hC3, 2'd0, 1'b1, 4'b0000, 1'b0, 4'b1000, 32'h44332277, 4'd8});
    tv.push_back('{1'b0, 1'b1, 8'hC3, 2'd0, 1'b1, 4'b1000, 1'b1, 4'b1111, 32'hC3C3C3C3, 4'd9});
    tv.push_back('{1'b1, 1'b1, 8'h99, 2'd1, 1'b0, 4'b0010, 1'b1, 4'b0000, 32'h00000000, 4'd0});
    tv.push_back('{1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'h00000000, 4'd0});
    rst = 1; in_valid = 0; in_data = 0; in_sel = 0; in_bcast = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < tv.size(); i++) apply(tv[i], i);
    for (int i = 0; i < 18; i++) begin
      vec_t t;
      t = '{1'b0, 1'b1, 8'(i + 8'h80), 2'd0, 1'b0, 4'b0001, 1'b1, 4'b0001,
            {24'h0, 8'(i + 8'h80)}, (i >= 14) ? 4'hF : 4'(i + 1)};
      apply(t, 100 + i);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_result_router.md
# alu_result_router

Registered 1-to-4 result router at the ALU output. Accepts one WIDTH-bit result per transfer with a 2-bit destination select, or a broadcast flag, and delivers it to one or all four destination channels. Each channel has a one-entry holding register with an independent valid/ready handshake. Sits directly downstream of the ALU's 1-to-4 demux select path and gives that routing stage backpressure and registered outputs.

## Interface
Reset is synchronous and active-high, on the single clock `clk`.

Parameters:
- WIDTH, 8, data width of results and of each channel register
- CNT_W, 16, width of the accepted-transfer counter

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream result valid
- in_ready  out  1  router can accept this cycle (combinational)
- in_data  in  WIDTH  result value
- in_sel  in  2  destination channel 0..3 (s[1:0] encoding: 0 = ch0, 1 = ch1, 2 = ch2, 3 = ch3)
- in_bcast  in  1  when 1, the transfer goes to all four channels and in_sel is ignored
- out_valid  out  4  bit k is high when channel k holds data
- out_ready  in  4  bit k is high when the consumer of channel k takes data this cycle
- out_data  out  4*WIDTH  channel k data at bits [k*WIDTH +: WIDTH]
- xfer_count  out  CNT_W  number of accepted input transfers; saturates at all-ones

## Operation

Channel states:
- Each channel k is EMPTY (out_valid[k] = 0) or FULL (out_valid[k] = 1).
- Channel k can accept when it is EMPTY, or when it is FULL and out_ready[k] = 1 in the same cycle (drain-and-refill).

Ready rules:
- Unicast (in_bcast = 0): in_ready = can_accept[in_sel].
- Broadcast (in_bcast = 1): in_ready = AND of can_accept over all four channels. All four channels load together or none do; there is no partial broadcast.

Accept and load:
- A transfer is accepted when in_valid && in_ready.
- Targeted channels load in_data and become FULL at the next edge.
- Each accepted transfer increments xfer_count by 1, including broadcasts (one increment per broadcast, not four). xfer_count holds at 2^CNT_W − 1.

Drain:
- When out_valid[k] && out_ready[k], channel k goes to EMPTY at the next edge, unless it reloads in the same cycle.
- On reload it stays FULL and takes the new data.
- out_ready[k] while out_valid[k] = 0 has no effect.

Data stability:
- out_data of a channel holds its value while FULL and not drained.
- An EMPTY channel keeps its last value; consumers must not sample it.

Independence: channels not targeted by a transfer are unaffected by it.

in_valid = 0: no state change except drains.

## Timing

Reset:
- With rst = 1 at an edge: out_valid = 4'b0000, out_data = 0, xfer_count = 0.
- Held data is discarded, including data that a consumer was accepting in that cycle.
- in_ready is still computed combinationally from the post-reset state. After reset all channels are EMPTY, so in_ready = 1 for any in_sel or in_bcast.
- A transfer presented in a reset cycle is not accepted, and the counter does not count it.

Latency:
- Input to out_valid is 1 cycle: accepted at edge N, visible after edge N.
- Minimum input-to-consumer latency is 1 cycle.

Throughput:
- 1 transfer per cycle to the same channel when out_ready for that channel is held high.
- 1 transfer per cycle when rotating across channels, even with no draining, until each channel is FULL.

Combinational paths: in_ready depends combinationally on in_sel, in_bcast and out_ready. There is no combinational path from in_data to out_data.

Upstream handshake: upstream must hold in_valid, in_data, in_sel and in_bcast stable until accepted. The router does not require this for correctness.

## Test plan
- **Reset defaults.** After rst, expect out_valid = 0000, xfer_count = 0, in_ready = 1. Then send in_data = 8'hA5 with in_sel = 2 → one cycle later out_valid = 0100, channel 2 data = A5, xfer_count = 1.
- **Unicast sweep.** Send 8'h11, 8'h22, 8'h33, 8'h44 to sel 0..3 with out_ready = 0000 → out_valid = 1111 with the matching data. A fifth transfer to sel 1 sees in_ready = 0 and channel 1 still holds 22.
- **Drain-and-refill.** Channel 0 is FULL with 11. Hold out_ready[0] = 1 and stream 8'h55, 8'h66, 8'h77 to sel 0 → in_ready stays 1, out_valid[0] stays 1, data goes 11 → 55 → 66 → 77 on consecutive cycles, and xfer_count rises by 3.
- **Broadcast blocking.** Channel 3 is FULL with out_ready = 0000. Broadcast 8'hC3 → in_ready = 0 and no channel changes. Raise out_ready[3] → the broadcast is accepted, all four channels hold C3, and xfer_count rises by 1.
- **Reset mid-operation.** Channels are FULL with out_ready[1] = 1, and a unicast to sel 1 is pending. Assert rst for 1 cycle → out_valid = 0000, all out_data = 0, xfer_count = 0, and the pending transfer is not counted.
- **Counter saturation.** With CNT_W = 4, make 17 accepted transfers → xfer_count = 4'hF and holds at 4'hF.
